// File: rtl/mw_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mw_alu_seq
// Description : 64-bit sequencer that runs each operation as four 16-bit
//               passes through an external 16-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module mw_alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [63:0] cmd_a,
    input  logic [63:0] cmd_b,
    input  logic        cmd_cin,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_cin,
    input  logic [15:0] alu_result,
    input  logic [5:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [5:0]  rsp_flags,
    output logic        rsp_err
);

    localparam logic [4:0] C_OP_NOP = 5'b00000;
    localparam logic [4:0] C_OP_ADD = 5'b00100;
    localparam logic [4:0] C_OP_ADC = 5'b00101;
    localparam logic [4:0] C_OP_SUB = 5'b00110;
    localparam logic [4:0] C_OP_SBB = 5'b00111;
    localparam logic [4:0] C_OP_AND = 5'b01000;
    localparam logic [4:0] C_OP_OR  = 5'b01001;
    localparam logic [4:0] C_OP_XOR = 5'b01010;
    localparam logic [4:0] C_OP_NOT = 5'b01011;
    localparam logic [4:0] C_OP_SHL = 5'b10000;
    localparam logic [4:0] C_OP_SHR = 5'b10001;
    localparam logic [4:0] C_OP_SAR = 5'b10011;
    localparam logic [4:0] C_OP_RCL = 5'b10110;
    localparam logic [4:0] C_OP_RCR = 5'b10111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_res;
    logic [4:0]  r_op;
    logic        r_cin;
    logic [1:0]  r_cnt;
    logic        r_cf;
    logic        r_af0;

    logic        w_is_add;
    logic        w_is_sub;
    logic        w_is_logic;
    logic        w_is_shl;
    logic        w_is_shr;
    logic        w_is_arith;
    logic        w_op_ok;
    logic        w_last;
    logic [1:0]  w_idx;
    logic [4:0]  w_word_f;
    logic        w_word_cin;
    logic [63:0] w_res_nxt;
    logic        w_fin_cf;
    logic        w_fin_vf;
    logic        w_fin_af;
    logic [63:0] w_fin_data;
    logic [5:0]  w_fin_flags;
    logic        w_fin_err;
    logic [2:0]  w_unused_status;

    // The 64-bit ZF/NF/PF are derived from the assembled result, not the ALU.
    assign w_unused_status = {alu_status[4:3], alu_status[1]};

    assign w_is_add   = (r_op == C_OP_ADD) || (r_op == C_OP_ADC);
    assign w_is_sub   = (r_op == C_OP_SUB) || (r_op == C_OP_SBB);
    assign w_is_logic = (r_op == C_OP_AND) || (r_op == C_OP_OR) ||
                        (r_op == C_OP_XOR) || (r_op == C_OP_NOT);
    assign w_is_shl   = (r_op == C_OP_SHL);
    assign w_is_shr   = (r_op == C_OP_SHR) || (r_op == C_OP_SAR);
    assign w_is_arith = w_is_add || w_is_sub;
    assign w_op_ok    = w_is_arith || w_is_logic || w_is_shl || w_is_shr;
    assign w_last     = (r_cnt == 2'd3);

    // Right shifts walk the words from the top so the carry feeds downward.
    assign w_idx = w_is_shr ? ~r_cnt : r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_word_f   = C_OP_NOP;
        w_word_cin = 1'b0;
        if (r_cnt == 2'd0) begin
            case (r_op)
                C_OP_ADD: w_word_f = C_OP_ADD;
                C_OP_ADC: begin
                    w_word_f   = C_OP_ADC;
                    w_word_cin = r_cin;
                end
                C_OP_SUB: w_word_f = C_OP_SUB;
                C_OP_SBB: begin
                    w_word_f   = C_OP_SBB;
                    w_word_cin = r_cin;
                end
                C_OP_AND, C_OP_OR, C_OP_XOR, C_OP_NOT: w_word_f = r_op;
                C_OP_SHL: w_word_f = C_OP_SHL;
                C_OP_SHR: w_word_f = C_OP_SHR;
                C_OP_SAR: w_word_f = C_OP_SAR;
                default:  w_word_f = C_OP_NOP;
            endcase
        end else begin
            case (r_op)
                C_OP_ADD, C_OP_ADC: begin
                    w_word_f   = C_OP_ADC;
                    w_word_cin = r_cf;
                end
                C_OP_SUB, C_OP_SBB: begin
                    w_word_f   = C_OP_SBB;
                    w_word_cin = r_cf;
                end
                C_OP_AND, C_OP_OR, C_OP_XOR, C_OP_NOT: w_word_f = r_op;
                C_OP_SHL: begin
                    w_word_f   = C_OP_RCL;
                    w_word_cin = r_cf;
                end
                C_OP_SHR, C_OP_SAR: begin
                    w_word_f   = C_OP_RCR;
                    w_word_cin = r_cf;
                end
                default:  w_word_f = C_OP_NOP;
            endcase
        end
    end

    always_comb begin
        alu_a   = 16'd0;
        alu_b   = 16'd0;
        alu_f   = C_OP_NOP;
        alu_cin = 1'b0;
        if (r_state == S_EXEC) begin
            alu_a   = r_a[{w_idx, 4'b0000} +: 16];
            alu_b   = r_b[{w_idx, 4'b0000} +: 16];
            alu_f   = w_word_f;
            alu_cin = w_word_cin;
        end
    end

    always_comb begin
        w_res_nxt                          = r_res;
        w_res_nxt[{w_idx, 4'b0000} +: 16]  = alu_result;
    end

    // Final flags are evaluated while the last word is on the ALU.
    assign w_fin_cf = (w_is_arith || w_is_shl || w_is_shr) && alu_status[5];
    assign w_fin_vf = w_is_arith && alu_status[2];
    assign w_fin_af = w_is_arith && r_af0;

    always_comb begin
        w_fin_data  = w_res_nxt;
        w_fin_flags = {w_fin_cf, (w_res_nxt == 64'd0), w_res_nxt[63],
                       w_fin_vf, ~^w_res_nxt, w_fin_af};
        w_fin_err   = 1'b0;
        if (!w_op_ok) begin
            w_fin_data  = 64'd0;
            w_fin_flags = 6'd0;
            w_fin_err   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= 64'd0;
            r_b       <= 64'd0;
            r_res     <= 64'd0;
            r_op      <= C_OP_NOP;
            r_cin     <= 1'b0;
            r_cnt     <= 2'd0;
            r_cf      <= 1'b0;
            r_af0     <= 1'b0;
            rsp_data  <= 64'd0;
            rsp_flags <= 6'd0;
            rsp_err   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_op  <= cmd_op;
                r_cin <= cmd_cin;
                r_cnt <= 2'd0;
                r_res <= 64'd0;
                r_cf  <= 1'b0;
                r_af0 <= 1'b0;
            end else if (r_state == S_EXEC) begin
                r_res <= w_res_nxt;
                r_cf  <= alu_status[5];
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd0) begin
                    r_af0 <= alu_status[0];
                end
                if (w_last) begin
                    rsp_data  <= w_fin_data;
                    rsp_flags <= w_fin_flags;
                    rsp_err   <= w_fin_err;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mw_alu_seq.sv
`default_nettype none
// Directed bench for mw_alu_seq with a behavioural 16-bit ALU attached.
module tb_mw_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic        cmd_cin;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic [5:0]  alu_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [5:0]  rsp_flags;
    logic        rsp_err;

    int total;
    int bad;

    mw_alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model, status {CF,ZF,NF,VF,PF,AF}
    logic [16:0] m_t;
    logic [15:0] m_res;
    logic        m_cf;
    logic        m_vf;
    logic        m_af;
    always_comb begin
        m_t   = 17'd0;
        m_res = 16'd0;
        m_cf  = 1'b0;
        m_vf  = 1'b0;
        m_af  = 1'b0;
        case (alu_f)
            5'b00100, 5'b00101: begin
                m_t   = {1'b0, alu_a} + {1'b0, alu_b} +
                        ((alu_f == 5'b00101) ? {16'd0, alu_cin} : 17'd0);
                m_res = m_t[15:0];
                m_cf  = m_t[16];
                m_vf  = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
                m_af  = alu_a[4] ^ alu_b[4] ^ m_res[4];
            end
            5'b00110, 5'b00111: begin
                m_t   = {1'b0, alu_a} - {1'b0, alu_b} -
                        ((alu_f == 5'b00111) ? {16'd0, alu_cin} : 17'd0);
                m_res = m_t[15:0];
                m_cf  = m_t[16];
                m_vf  = (alu_a[15] != alu_b[15]) && (m_res[15] != alu_a[15]);
                m_af  = alu_a[4] ^ alu_b[4] ^ m_res[4];
            end
            5'b01000: m_res = alu_a & alu_b;
            5'b01001: m_res = alu_a | alu_b;
            5'b01010: m_res = alu_a ^ alu_b;
            5'b01011: m_res = ~alu_a;
            5'b10000: begin m_res = {alu_a[14:0], 1'b0};    m_cf = alu_a[15]; end
            5'b10110: begin m_res = {alu_a[14:0], alu_cin}; m_cf = alu_a[15]; end
            5'b10001: begin m_res = {1'b0, alu_a[15:1]};    m_cf = alu_a[0];  end
            5'b10011: begin m_res = {alu_a[15], alu_a[15:1]}; m_cf = alu_a[0]; end
            5'b10111: begin m_res = {alu_cin, alu_a[15:1]}; m_cf = alu_a[0];  end
            default: m_res = 16'd0;
        endcase
    end
    assign alu_result = m_res;
    assign alu_status = {m_cf, (m_res == 16'd0), m_res[15], m_vf, ~^m_res, m_af};

    task automatic send_cmd(input logic [4:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic cin);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({rsp_data, rsp_flags, rsp_err} !== 71'd0) begin bad++; $display("FAIL reset_rsp got=%h/%b/%b exp=0", rsp_data, rsp_flags, rsp_err); end
        total++; if ({alu_a, alu_b, alu_f, alu_cin} !== 38'd0) begin bad++; $display("FAIL reset_alu got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_f, alu_cin); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        send_cmd(5'b00100, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        total++; if (alu_f !== 5'b00100 || alu_a !== 16'hFFFF) begin bad++; $display("FAIL add_word0 got=%b/%h exp=00100/ffff", alu_f, alu_a); end
        wait_rsp(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
        total++; if (rsp_data !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL add_data got=%h exp=0000000100000000", rsp_data); end
        total++; if (rsp_flags !== 6'b000001 || rsp_err !== 1'b0) begin bad++; $display("FAIL add_flags got=%b/%b exp=000001/0", rsp_flags, rsp_err); end
        release_rsp();
    endtask

    task automatic test_sub_ovf();
        int lat;
        send_cmd(5'b00110, 64'd0, 64'd1, 1'b0);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL sub_data got=%h exp=ffffffffffffffff", rsp_data); end
        total++; if (rsp_flags !== 6'b101011) begin bad++; $display("FAIL sub_flags got=%b exp=101011", rsp_flags); end
        release_rsp();
        send_cmd(5'b00100, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_data got=%h exp=8000000000000000", rsp_data); end
        total++; if (rsp_flags !== 6'b001101) begin bad++; $display("FAIL ovf_flags got=%b exp=001101", rsp_flags); end
        release_rsp();
    endtask

    task automatic test_shift();
        int lat;
        logic [2:0] exp_cin;
        exp_cin = 3'b001;
        send_cmd(5'b10001, 64'h0001_0000_0000_0001, 64'd0, 1'b0);
        total++; if (alu_f !== 5'b10001 || alu_a !== 16'h0001 || alu_cin !== 1'b0) begin bad++; $display("FAIL shr_word3 got=%b/%h/%b exp=10001/0001/0", alu_f, alu_a, alu_cin); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++; if (alu_f !== 5'b10111 || alu_cin !== exp_cin[k]) begin bad++; $display("FAIL shr_rcr%0d got=%b/%b exp=10111/%b", k, alu_f, alu_cin, exp_cin[k]); end
        end
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL shr_valid got=%b exp=1", rsp_valid); end
        wait_rsp(lat);
        total++; if (rsp_data !== 64'h0000_8000_0000_0000 || rsp_flags !== 6'b100000) begin bad++; $display("FAIL shr_result got=%h/%b exp=0000800000000000/100000", rsp_data, rsp_flags); end
        release_rsp();
        send_cmd(5'b10011, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'hC000_0000_0000_0000 || rsp_flags !== 6'b001010) begin bad++; $display("FAIL sar_result got=%h/%b exp=c000000000000000/001010", rsp_data, rsp_flags); end
        release_rsp();
    endtask

    task automatic test_carry_in();
        int lat;
        send_cmd(5'b00101, 64'd0, 64'd0, 1'b1);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'd1 || rsp_flags !== 6'b000000) begin bad++; $display("FAIL adc_result got=%h/%b exp=1/000000", rsp_data, rsp_flags); end
        release_rsp();
        send_cmd(5'b00111, 64'd0, 64'd0, 1'b1);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_flags !== 6'b101011) begin bad++; $display("FAIL sbb_result got=%h/%b exp=ffffffffffffffff/101011", rsp_data, rsp_flags); end
        release_rsp();
    endtask

    task automatic test_logic();
        int lat;
        send_cmd(5'b01000, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
        total++; if (alu_cin !== 1'b0) begin bad++; $display("FAIL and_cin got=%b exp=0", alu_cin); end
        wait_rsp(lat);
        total++; if (rsp_data !== 64'h0204_0608_0A0C_0E00 || rsp_flags !== 6'b000010) begin bad++; $display("FAIL and_result got=%h/%b exp=020406080a0c0e00/000010", rsp_data, rsp_flags); end
        release_rsp();
        send_cmd(5'b01010, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'd0 || rsp_flags !== 6'b010010) begin bad++; $display("FAIL xor_result got=%h/%b exp=0/010010", rsp_data, rsp_flags); end
        release_rsp();
        send_cmd(5'b01011, 64'd0, 64'h5555, 1'b0);
        wait_rsp(lat);
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_flags !== 6'b001010) begin bad++; $display("FAIL not_result got=%h/%b exp=ffffffffffffffff/001010", rsp_data, rsp_flags); end
        release_rsp();
    endtask

    task automatic test_hold_err();
        int lat;
        send_cmd(5'b00100, 64'd1, 64'd2, 1'b0);
        wait_rsp(lat);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = 5'b01010;
            cmd_a     = 64'hFFFF_0000_FFFF_0000;
            @(posedge clk);
            #1;
            total++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_hs%0d got=%b/%b exp=1/0", k, rsp_valid, cmd_ready); end
            total++; if (rsp_data !== 64'd3 || rsp_flags !== 6'b000010 || rsp_err !== 1'b0) begin bad++; $display("FAIL hold_data%0d got=%h/%b/%b exp=3/000010/0", k, rsp_data, rsp_flags, rsp_err); end
        end
        cmd_valid = 1'b0;
        release_rsp();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL hold_idle got=%b exp=1", cmd_ready); end
        send_cmd(5'b00001, 64'h1234, 64'h5678, 1'b1);
        total++; if (alu_f !== 5'b00000) begin bad++; $display("FAIL err_alu_f got=%b exp=00000", alu_f); end
        wait_rsp(lat);
        total++; if (lat !== 4 || rsp_err !== 1'b1 || rsp_data !== 64'd0 || rsp_flags !== 6'd0) begin bad++; $display("FAIL err_rsp got=lat%0d/%b/%h/%b exp=lat4/1/0/000000", lat, rsp_err, rsp_data, rsp_flags); end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        int first;
        int second;
        logic [63:0] seen;
        first  = -1;
        second = -1;
        seen   = 64'hX;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 5'b00100;
        cmd_a     = 64'd10;
        cmd_b     = 64'd20;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && second < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (rsp_valid) seen = rsp_data;
            if (cmd_ready) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        total++; if (second - first !== 6) begin bad++; $display("FAIL b2b_spacing got=%0d exp=6", second - first); end
        total++; if (seen !== 64'd30) begin bad++; $display("FAIL b2b_data got=%h exp=1e", seen); end
        wait_rsp(lat);
        release_rsp();
    endtask

    task automatic test_async_reset();
        int lat;
        int seen;
        send_cmd(5'b00100, 64'd5, 64'd7, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL arst_hs got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
        total++; if ({alu_a, alu_b, alu_f, alu_cin} !== 38'd0 || {rsp_data, rsp_flags, rsp_err} !== 71'd0) begin bad++; $display("FAIL arst_out got=%h/%b/%h exp=0", alu_a, alu_f, rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL arst_no_rsp got=%0d exp=0", seen); end
        send_cmd(5'b00100, 64'd1, 64'd1, 1'b0);
        wait_rsp(lat);
        total++; if (lat !== 4 || rsp_data !== 64'd2 || rsp_flags !== 6'd0) begin bad++; $display("FAIL arst_next got=lat%0d/%h/%b exp=lat4/2/000000", lat, rsp_data, rsp_flags); end
        release_rsp();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 5'd0;
        cmd_a     = 64'd0;
        cmd_b     = 64'd0;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_ovf();
        test_shift();
        test_carry_in();
        test_logic();
        test_hold_err();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
